sumador_vuelto_param: RTL and testbench
=======================================

// Module: sumador_vuelto_param
// PURPOSE
//  Parametrised vending-machine credit/change controller. Accumulates inserted coins,
//  checks the selected product price, pulses a vend, then pays change coin-by-coin
//  (greedy, largest coin first) over a valid/ready handshake to the coin hopper.
//  Sits between the coin acceptor / keypad front-end and the dispenser/hopper drivers.
// PARAMETERS
//  W          12                       credit/price/change width (bits)
//  N_PROD     4                        number of products, 1..8
//  PRICES     {12'd700,12'd500,12'd400,12'd300}  packed N_PROD*W; product i = PRICES[i*W+:W]
//  COIN_V0..3 25, 50, 100, 500         coin values, strictly ascending; index = coin_sel code
//  MAX_CREDIT 2000                     credit ceiling (<= 2**W-1)
// PORTS
//  clk            in   1  clock, all logic on posedge
//  rst            in   1  reset
//  coin_valid     in   1  one-cycle pulse: coin inserted
//  coin_sel       in   2  inserted coin index (COIN_V0..3)
//  sel_valid      in   1  one-cycle pulse: product requested
//  sel            in   3  product index
//  cancel         in   1  one-cycle pulse: return full credit
//  credito        out  W  current credit
//  vuelto         out  W  change amount of last vend/cancel, held until next one
//  producto_valid out  1  one-cycle vend pulse
//  producto_sel   out  3  product vended, valid with producto_valid
//  fallo          out  1  one-cycle pulse: insufficient credit or invalid sel
//  coin_reject    out  1  one-cycle pulse: inserted coin refused (return chute)
//  coin_out_valid out  1  change coin request to hopper
//  coin_out_sel   out  2  change coin index
//  coin_out_ready in   1  hopper accepted coin
//  busy           out  1  high in CHANGE state
// BEHAVIOUR
//  Reset is synchronous and active-high (rst sampled on posedge clk).
//  Reset: state IDLE, credito=0, vuelto=0, remaining=0, all pulses/valid/busy=0,
//   producto_sel=0, coin_out_sel=0. Reset mid-CHANGE aborts payout; coin_out_valid low next cycle.
//  States: IDLE, CHANGE. All outputs registered; response 1 cycle after input pulse.
//  IDLE, per-cycle priority cancel > sel_valid > coin_valid:
//   - cancel: vuelto<=credito, remaining<=credito, credito<=0, -> CHANGE (credito=0 stays IDLE).
//   - sel_valid, sel<N_PROD, credito>=price: producto_valid=1, producto_sel=sel,
//     vuelto<=credito-price, remaining<=same, credito<=0; -> CHANGE if remaining!=0 else IDLE.
//   - sel_valid, sel>=N_PROD or credito<price: fallo=1, credito unchanged, stay IDLE.
//   - coin_valid alone: credito<=credito+COIN_V[coin_sel] if result<=MAX_CREDIT,
//     else coin_reject=1, credito unchanged. Compare on W+1-bit sum (no wrap).
//   - coin_valid together with cancel or sel_valid: coin_reject=1, coin not credited.
//  CHANGE: busy=1; coin_out_valid=1, coin_out_sel = highest k with COIN_Vk<=remaining.
//   - valid and sel held stable until coin_out_ready; on valid&ready remaining-=COIN_V[sel],
//     sel recomputed next cycle; back-to-back coins with ready held high.
//   - remaining==0 -> IDLE, coin_out_valid=0 same cycle as transition.
//   - 0<remaining<COIN_V0: residue moved to credito, -> IDLE, no fallo.
//   - coin_valid -> coin_reject; sel_valid -> fallo; cancel ignored.
// TESTING
//  rst; coins 100,100,100,50; sel=0 -> credito=350, producto_valid(sel 0), vuelto=50, one coin_out idx1, credito=0.
//  credito=100; sel=3 (700) -> fallo 1 cycle, credito=100; sel=5 -> fallo, no vend.
//  credito=675, cancel, ready low 3 cycles then high -> coins idx3,2,1,0 in order; sel stable while stalled; vuelto=675.
//  credito=1800, insert 500 -> coin_reject, credito=1800; insert 100 -> credito=1900.
//  coin_valid+sel_valid same cycle (credito 400, sel=1) -> vend, vuelto=0, coin_reject, stays IDLE.
//  rst during CHANGE after 1 of 3 coins -> all outputs 0 next cycle, credito=0, IDLE.

Source files
------------

// File: rtl/sumador_vuelto_param.sv
// Vending credit/change controller: credits coins, vends on sufficient credit, pays change greedily.
// Registered outputs, 1-cycle response; change coins held stable on coin_out_valid until coin_out_ready.
module sumador_vuelto_param #(
    parameter int unsigned         W          = 12,
    parameter int unsigned         N_PROD     = 4,
    parameter logic [N_PROD*W-1:0] PRICES     = {12'd700, 12'd500, 12'd400, 12'd300},
    parameter int unsigned         COIN_V0    = 25,
    parameter int unsigned         COIN_V1    = 50,
    parameter int unsigned         COIN_V2    = 100,
    parameter int unsigned         COIN_V3    = 500,
    parameter int unsigned         MAX_CREDIT = 2000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         coin_valid,
    input  logic [1:0]   coin_sel,
    input  logic         sel_valid,
    input  logic [2:0]   sel,
    input  logic         cancel,
    output logic [W-1:0] credito,
    output logic [W-1:0] vuelto,
    output logic         producto_valid,
    output logic [2:0]   producto_sel,
    output logic         fallo,
    output logic         coin_reject,
    output logic         coin_out_valid,
    output logic [1:0]   coin_out_sel,
    input  logic         coin_out_ready,
    output logic         busy
);

    typedef enum logic {IDLE = 1'b0, CHANGE = 1'b1} state_t;

    localparam logic [W-1:0] CV0   = W'(COIN_V0);
    localparam logic [W-1:0] CV1   = W'(COIN_V1);
    localparam logic [W-1:0] CV2   = W'(COIN_V2);
    localparam logic [W-1:0] CV3   = W'(COIN_V3);
    localparam logic [W:0]   MAX_C = (W+1)'(MAX_CREDIT);

    function automatic logic [W-1:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd0:    return CV0;
            2'd1:    return CV1;
            2'd2:    return CV2;
            default: return CV3;
        endcase
    endfunction

    // Largest coin that still fits; 0 when nothing fits (valid is low then anyway).
    function automatic logic [1:0] pick_coin(input logic [W-1:0] r);
        if (r >= CV3)      return 2'd3;
        else if (r >= CV2) return 2'd2;
        else if (r >= CV1) return 2'd1;
        else               return 2'd0;
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] credito_q, credito_d, vuelto_q, vuelto_d, remaining_q, remaining_d;
    logic         producto_valid_q, producto_valid_d, fallo_q, fallo_d;
    logic         coin_reject_q, coin_reject_d, coin_out_valid_q, coin_out_valid_d;
    logic         busy_q, busy_d;
    logic [2:0]   producto_sel_q, producto_sel_d;
    logic [1:0]   coin_out_sel_q, coin_out_sel_d;

    logic [W-1:0] price;
    logic         sel_ok;
    logic [W:0]   coin_sum;
    logic [W-1:0] credito_pre, rem_pre;
    logic         go_change;

    always_comb begin
        price  = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < int'(N_PROD); i++) begin
            if (sel == 3'(i)) begin
                price  = PRICES[i*W +: W];
                sel_ok = 1'b1;
            end
        end
    end

    assign coin_sum = {1'b0, credito_q} + {1'b0, coin_value(coin_sel)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            credito_q        <= '0;
            vuelto_q         <= '0;
            remaining_q      <= '0;
            producto_valid_q <= 1'b0;
            producto_sel_q   <= '0;
            fallo_q          <= 1'b0;
            coin_reject_q    <= 1'b0;
            coin_out_valid_q <= 1'b0;
            coin_out_sel_q   <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            credito_q        <= credito_d;
            vuelto_q         <= vuelto_d;
            remaining_q      <= remaining_d;
            producto_valid_q <= producto_valid_d;
            producto_sel_q   <= producto_sel_d;
            fallo_q          <= fallo_d;
            coin_reject_q    <= coin_reject_d;
            coin_out_valid_q <= coin_out_valid_d;
            coin_out_sel_q   <= coin_out_sel_d;
            busy_q           <= busy_d;
        end
    end

    // Event decode: what this cycle's inputs do to credit and the amount still owed.
    always_comb begin
        go_change        = 1'b0;
        rem_pre          = remaining_q;
        credito_pre      = credito_q;
        vuelto_d         = vuelto_q;
        producto_valid_d = 1'b0;
        producto_sel_d   = producto_sel_q;
        fallo_d          = 1'b0;
        coin_reject_d    = 1'b0;
        if (state_q == IDLE) begin
            if (cancel) begin
                coin_reject_d = coin_valid;
                vuelto_d      = credito_q;
                rem_pre       = credito_q;
                credito_pre   = '0;
                go_change     = 1'b1;
            end else if (sel_valid) begin
                coin_reject_d = coin_valid;
                if (sel_ok && (credito_q >= price)) begin
                    producto_valid_d = 1'b1;
                    producto_sel_d   = sel;
                    vuelto_d         = credito_q - price;
                    rem_pre          = credito_q - price;
                    credito_pre      = '0;
                    go_change        = 1'b1;
                end else begin
                    fallo_d = 1'b1;
                end
            end else if (coin_valid) begin
                if (coin_sum <= MAX_C) credito_pre   = coin_sum[W-1:0];
                else                   coin_reject_d = 1'b1;
            end
        end else begin
            coin_reject_d = coin_valid;
            fallo_d       = sel_valid;
            go_change     = 1'b1;
            if (coin_out_valid_q && coin_out_ready)
                rem_pre = remaining_q - coin_value(coin_out_sel_q);
        end
    end

    always_comb begin
        state_d = IDLE;
        if (go_change && (rem_pre >= CV0)) state_d = CHANGE;
    end

    // A residue too small for any coin goes back into credit instead of being paid.
    always_comb begin
        credito_d        = credito_pre;
        remaining_d      = '0;
        if (go_change && (rem_pre < CV0)) credito_d = credito_pre + rem_pre;
        if (state_d == CHANGE) remaining_d = rem_pre;
        coin_out_valid_d = (state_d == CHANGE);
        busy_d           = (state_d == CHANGE);
        coin_out_sel_d   = pick_coin(remaining_d);
    end

    assign credito        = credito_q;
    assign vuelto         = vuelto_q;
    assign producto_valid = producto_valid_q;
    assign producto_sel   = producto_sel_q;
    assign fallo          = fallo_q;
    assign coin_reject    = coin_reject_q;
    assign coin_out_valid = coin_out_valid_q;
    assign coin_out_sel   = coin_out_sel_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_sumador_vuelto_param.sv
// Bench for sumador_vuelto_param: transaction-level model plus directed scenarios with literal expectations.
module tb_sumador_vuelto_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin_sel = 2'd0;
    logic        sel_valid = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        cancel = 1'b0;
    logic        coin_out_ready = 1'b1;
    logic [11:0] credito, vuelto;
    logic        producto_valid, fallo, coin_reject, coin_out_valid, busy;
    logic [2:0]  producto_sel;
    logic [1:0]  coin_out_sel;

    sumador_vuelto_param dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .credito(credito), .vuelto(vuelto), .producto_valid(producto_valid),
        .producto_sel(producto_sel), .fallo(fallo), .coin_reject(coin_reject),
        .coin_out_valid(coin_out_valid), .coin_out_sel(coin_out_sel),
        .coin_out_ready(coin_out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    int price [4] = '{300, 400, 500, 700};
    int cval  [4] = '{25, 50, 100, 500};

    int m_cred = 0, m_vuel = 0, m_pv = 0, m_psel = 0, m_fallo = 0, m_rej = 0;
    int m_pay = 0, m_resid = 0;
    int m_q[$];
    int log_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Payout plan: greedy coin list decided up front; leftover under the smallest coin is returned to credit.
    task automatic start_pay(input int amt);
        int a;
        a = amt;
        m_q.delete();
        for (int k = 3; k >= 0; k--)
            while (a >= cval[k]) begin
                m_q.push_back(k);
                a -= cval[k];
            end
        m_resid = a;
        if (m_q.size() == 0) begin
            m_cred = m_cred + a;
            m_pay  = 0;
        end else begin
            m_pay = 1;
        end
    endtask

    always @(posedge clk) begin
        m_pv = 0; m_fallo = 0; m_rej = 0;
        if (rst) begin
            m_cred = 0; m_vuel = 0; m_psel = 0; m_pay = 0; m_resid = 0;
            m_q.delete();
        end else if (m_pay == 0) begin
            if (cancel) begin
                m_rej  = int'(coin_valid);
                m_vuel = m_cred;
                m_cred = 0;
                start_pay(m_vuel);
            end else if (sel_valid) begin
                m_rej = int'(coin_valid);
                if (sel < 4 && m_cred >= price[sel]) begin
                    m_pv   = 1;
                    m_psel = int'(sel);
                    m_vuel = m_cred - price[sel];
                    m_cred = 0;
                    start_pay(m_vuel);
                end else begin
                    m_fallo = 1;
                end
            end else if (coin_valid) begin
                if (m_cred + cval[coin_sel] <= 2000) m_cred = m_cred + cval[coin_sel];
                else                                 m_rej  = 1;
            end
        end else begin
            m_rej   = int'(coin_valid);
            m_fallo = int'(sel_valid);
            if (coin_out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_pay  = 0;
                    m_cred = m_cred + m_resid;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("credito", int'(credito), m_cred);
            chk("vuelto", int'(vuelto), m_vuel);
            chk("producto_valid", int'(producto_valid), m_pv);
            if (m_pv != 0) chk("producto_sel", int'(producto_sel), m_psel);
            chk("fallo", int'(fallo), m_fallo);
            chk("coin_reject", int'(coin_reject), m_rej);
            chk("coin_out_valid", int'(coin_out_valid), m_pay);
            if (m_pay != 0) chk("coin_out_sel", int'(coin_out_sel), m_q[0]);
            chk("busy", int'(busy), m_pay);
        end
    end

    always @(negedge clk)
        if (coin_out_valid && coin_out_ready) log_q.push_back(int'(coin_out_sel));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int c);
        coin_valid = 1'b1; coin_sel = 2'(c);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic pick(input int s);
        sel_valid = 1'b1; sel = 3'(s);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("payout terminates", int'(busy), 0);
    endtask

    initial begin
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst credito", int'(credito), 0);
        chk("rst vuelto", int'(vuelto), 0);
        chk("rst coin_out_valid", int'(coin_out_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst producto_sel", int'(producto_sel), 0);
        chk("rst coin_out_sel", int'(coin_out_sel), 0);
        rst = 1'b0;

        // 100+100+100+50 then product 0 (300)
        coin(2); coin(2); coin(2); coin(1);
        chk("s1 credito", int'(credito), 350);
        pick(0);
        chk("s1 vend", int'(producto_valid), 1);
        chk("s1 vend sel", int'(producto_sel), 0);
        chk("s1 vuelto", int'(vuelto), 50);
        chk("s1 credito cleared", int'(credito), 0);
        chk("s1 coin_out_sel", int'(coin_out_sel), 1);
        wait_idle();
        chk("s1 coin count", log_q.size(), 1);
        chk("s1 coin idx", (log_q.size() > 0) ? log_q[0] : -1, 1);

        // insufficient credit and invalid selection
        do_reset();
        coin(2);
        pick(3);
        chk("s2 fallo price", int'(fallo), 1);
        chk("s2 credito kept", int'(credito), 100);
        tick();
        chk("s2 fallo one cycle", int'(fallo), 0);
        pick(5);
        chk("s2 fallo bad sel", int'(fallo), 1);
        chk("s2 no vend", int'(producto_valid), 0);

        // cancel 675 with stalled hopper
        do_reset();
        coin(3); coin(2); coin(1); coin(0);
        chk("s3 credito", int'(credito), 675);
        coin_out_ready = 1'b0;
        do_cancel();
        chk("s3 vuelto", int'(vuelto), 675);
        chk("s3 valid", int'(coin_out_valid), 1);
        chk("s3 sel", int'(coin_out_sel), 3);
        cancel = 1'b1; coin_valid = 1'b1; coin_sel = 2'd2;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        chk("s3 coin rejected in change", int'(coin_reject), 1);
        chk("s3 stall sel a", int'(coin_out_sel), 3);
        tick();
        chk("s3 stall sel b", int'(coin_out_sel), 3);
        tick();
        chk("s3 stall sel c", int'(coin_out_sel), 3);
        coin_out_ready = 1'b1;
        wait_idle();
        chk("s3 coin count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("s3 coin order", (log_q.size() > i) ? log_q[i] : -1, 3 - i);
        chk("s3 vuelto held", int'(vuelto), 675);

        // credit ceiling
        do_reset();
        coin(3); coin(3); coin(3); coin(2); coin(2); coin(2);
        chk("s4 credito", int'(credito), 1800);
        coin(3);
        chk("s4 reject", int'(coin_reject), 1);
        chk("s4 credito kept", int'(credito), 1800);
        coin(2);
        chk("s4 accept", int'(coin_reject), 0);
        chk("s4 credito 1900", int'(credito), 1900);

        // coin and selection in the same cycle
        do_reset();
        coin(2); coin(2); coin(2); coin(2);
        coin_valid = 1'b1; coin_sel = 2'd0; sel_valid = 1'b1; sel = 3'd1;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        chk("s5 vend", int'(producto_valid), 1);
        chk("s5 vend sel", int'(producto_sel), 1);
        chk("s5 vuelto", int'(vuelto), 0);
        chk("s5 reject", int'(coin_reject), 1);
        chk("s5 idle", int'(busy), 0);

        // reset in the middle of a payout
        do_reset();
        coin(3); coin(2); coin(1);
        do_cancel();
        chk("s6 first sel", int'(coin_out_sel), 3);
        tick();
        chk("s6 second sel", int'(coin_out_sel), 2);
        rst = 1'b1;
        tick();
        chk("s6 rst valid", int'(coin_out_valid), 0);
        chk("s6 rst busy", int'(busy), 0);
        chk("s6 rst credito", int'(credito), 0);
        chk("s6 rst vuelto", int'(vuelto), 0);
        rst = 1'b0;
        tick();
        chk("s6 stays idle", int'(coin_out_valid), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
